// File: rtl/pong_pkg.sv
// Shared definitions for the pong frame scheduler.
// Holds the FSM state encoding, default regfile indices of the game objects,
// the bit positions of the move buttons inside the button word, and a helper
// that builds the 32-bit word injected into the button register.
package pong_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int BTN_W  = 4;
    localparam int CNT_W  = 3;   // debounce counter, enough for 1..7 frames

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_COPY   = 2'd1;
    localparam logic [1:0] ST_INJECT = 2'd2;

    localparam int DEF_BALL_REG = 10;
    localparam int DEF_PADL_REG = 11;
    localparam int DEF_PADR_REG = 12;
    localparam int DEF_BTN_REG  = 13;

    // btn_raw / btn_state = {moveleft, moveright, moveup, movedown}
    localparam int BTN_DOWN  = 0;
    localparam int BTN_UP    = 1;
    localparam int BTN_RIGHT = 2;
    localparam int BTN_LEFT  = 3;

    function automatic logic [DATA_W-1:0] btn_word(input logic [BTN_W-1:0] btn);
        logic [DATA_W-1:0] w;
        w            = '0;
        w[BTN_DOWN]  = btn[BTN_DOWN];
        w[BTN_UP]    = btn[BTN_UP];
        w[BTN_RIGHT] = btn[BTN_RIGHT];
        w[BTN_LEFT]  = btn[BTN_LEFT];
        return w;
    endfunction

endpackage

// File: rtl/pong_btn_debounce.sv
// One move button: two-flop synchronizer followed by a frame-based debouncer.
// Ports:
//   clock, reset   : processor clock, asynchronous active-high reset
//   btn_raw        : raw asynchronous button level
//   step           : one-cycle strobe, once per frame, that advances the debouncer
//   btn_state      : debounced level
// A change is accepted only after DEBOUNCE_FRAMES consecutive steps that all
// disagree with the current btn_state (legal range 1..7).
module pong_btn_debounce
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    input  logic step,
    output logic btn_state
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_FRAMES);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_p0   <= 1'b0;
            sync_p1   <= 1'b0;
            cnt       <= '0;
            btn_state <= 1'b0;
        end else begin
            // synchronizer stage boundary
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
            // debounce stage boundary
            if (step) begin
                if (sync_p1 == btn_state) begin
                    cnt <= '0;
                end else if (cnt + CNT_W'(1) == LIMIT) begin
                    btn_state <= ~btn_state;
                    cnt       <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/pong_frame_scheduler.sv
// Per-frame game sequencer sitting between the processor and the regfile.
// Ports:
//   clock, reset          : processor clock, asynchronous active-high reset
//   vga_vs                : VGA V_SYNC (active low, asynchronous)
//   btn_raw[3:0]          : {moveleft, moveright, moveup, movedown}, asynchronous
//   proc_we/wreg/wdata    : processor regfile write port
//   rf_we/wreg/wdata      : regfile write port (processor passthrough or button injection)
//   ball_q/padl_q/padr_q  : tear-free shadow copies of the game-object words
//   btn_state             : debounced buttons
//   frame_count           : vblank counter
//   frame_tick            : one-cycle pulse after the button word was written
//   frame_overrun         : sticky, a vblank arrived while an injection was pending
// Processor writes to the game-object registers are snooped into working
// copies; those are copied to the shadows only at vblank start. The button word
// is injected into BTN_REG on the first free write slot after that copy, so the
// processor is never stalled.
module pong_frame_scheduler
    import pong_pkg::*;
#(
    parameter int BALL_REG        = DEF_BALL_REG,
    parameter int PADL_REG        = DEF_PADL_REG,
    parameter int PADR_REG        = DEF_PADR_REG,
    parameter int BTN_REG         = DEF_BTN_REG,
    parameter int DEBOUNCE_FRAMES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              vga_vs,
    input  logic [BTN_W-1:0]  btn_raw,
    input  logic              proc_we,
    input  logic [REG_W-1:0]  proc_wreg,
    input  logic [DATA_W-1:0] proc_wdata,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_wreg,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [DATA_W-1:0] ball_q,
    output logic [DATA_W-1:0] padl_q,
    output logic [DATA_W-1:0] padr_q,
    output logic [BTN_W-1:0]  btn_state,
    output logic [15:0]       frame_count,
    output logic              frame_tick,
    output logic              frame_overrun
);

    localparam logic [REG_W-1:0] BALL_IDX = REG_W'(BALL_REG);
    localparam logic [REG_W-1:0] PADL_IDX = REG_W'(PADL_REG);
    localparam logic [REG_W-1:0] PADR_IDX = REG_W'(PADR_REG);
    localparam logic [REG_W-1:0] BTN_IDX  = REG_W'(BTN_REG);

    logic              vs_p0;
    logic              vs_p1;
    logic              vs_p2;
    logic              vblank_evt;
    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              inject_now;
    logic              wr_any;
    logic              wr_ball;
    logic              wr_padl;
    logic              wr_padr;
    logic [DATA_W-1:0] ball_w;
    logic [DATA_W-1:0] padl_w;
    logic [DATA_W-1:0] padr_w;

    // vs_p2 holds the previous synced value, so this is the falling edge of V_SYNC
    assign vblank_evt = vs_p2 & ~vs_p1;

    // Register 0 is hard-wired zero in the regfile, so it is never snooped
    assign wr_any  = proc_we && (proc_wreg != '0);
    assign wr_ball = wr_any && (proc_wreg == BALL_IDX);
    assign wr_padl = wr_any && (proc_wreg == PADL_IDX);
    assign wr_padr = wr_any && (proc_wreg == PADR_IDX);

    // A vblank during INJECT abandons the pending write; the next COPY
    // produces a fresher button word anyway.
    assign inject_now = (state == ST_INJECT) && !proc_we && !vblank_evt;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (vblank_evt) state_nxt = ST_COPY;
            ST_COPY:   state_nxt = ST_INJECT;
            ST_INJECT: begin
                if (vblank_evt)    state_nxt = ST_COPY;
                else if (!proc_we) state_nxt = ST_IDLE;
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // rf_we is gated by reset directly so an in-flight injection (or a
    // processor write) never reaches the regfile while reset is asserted.
    always_comb begin
        rf_we    = ~reset & (inject_now | proc_we);
        rf_wreg  = inject_now ? BTN_IDX : proc_wreg;
        rf_wdata = inject_now ? btn_word(btn_state) : proc_wdata;
    end

    genvar b;
    generate
        for (b = 0; b < BTN_W; b++) begin : g_btn
            pong_btn_debounce #(
                .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
            ) u_debounce (
                .clock     (clock),
                .reset     (reset),
                .btn_raw   (btn_raw[b]),
                .step      (state == ST_COPY),
                .btn_state (btn_state[b])
            );
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vs_p0         <= 1'b0;
            vs_p1         <= 1'b0;
            vs_p2         <= 1'b0;
            state         <= ST_IDLE;
            ball_w        <= '0;
            padl_w        <= '0;
            padr_w        <= '0;
            ball_q        <= '0;
            padl_q        <= '0;
            padr_q        <= '0;
            frame_count   <= '0;
            frame_tick    <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            // vsync synchronizer stage boundary
            vs_p0 <= vga_vs;
            vs_p1 <= vs_p0;
            vs_p2 <= vs_p1;

            // control stage boundary
            state      <= state_nxt;
            frame_tick <= inject_now;
            if ((state == ST_INJECT) && vblank_evt) frame_overrun <= 1'b1;

            if (wr_ball) ball_w <= proc_wdata;
            if (wr_padl) padl_w <= proc_wdata;
            if (wr_padr) padr_w <= proc_wdata;

            // shadow stage boundary: a same-cycle processor write is forwarded
            if (state == ST_COPY) begin
                ball_q      <= wr_ball ? proc_wdata : ball_w;
                padl_q      <= wr_padl ? proc_wdata : padl_w;
                padr_q      <= wr_padr ? proc_wdata : padr_w;
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pong_frame_scheduler.sv
module tb_pong_frame_scheduler;

    localparam int DEB = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        vga_vs;
    logic [3:0]  btn_raw;
    logic        proc_we;
    logic [4:0]  proc_wreg;
    logic [31:0] proc_wdata;
    logic        rf_we;
    logic [4:0]  rf_wreg;
    logic [31:0] rf_wdata;
    logic [31:0] ball_q, padl_q, padr_q;
    logic [3:0]  btn_state;
    logic [15:0] frame_count;
    logic        frame_tick;
    logic        frame_overrun;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: frame-level view of the game state
    logic [31:0] m_work [3];
    logic [31:0] m_shad [3];
    logic [15:0] m_count;
    logic [3:0]  m_btn;
    int          m_dcnt [4];
    logic        m_ovr;

    pong_frame_scheduler dut (
        .clock         (clock),
        .reset         (reset),
        .vga_vs        (vga_vs),
        .btn_raw       (btn_raw),
        .proc_we       (proc_we),
        .proc_wreg     (proc_wreg),
        .proc_wdata    (proc_wdata),
        .rf_we         (rf_we),
        .rf_wreg       (rf_wreg),
        .rf_wdata      (rf_wdata),
        .ball_q        (ball_q),
        .padl_q        (padl_q),
        .padr_q        (padr_q),
        .btn_state     (btn_state),
        .frame_count   (frame_count),
        .frame_tick    (frame_tick),
        .frame_overrun (frame_overrun)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    function automatic int sidx(input logic [4:0] r);
        if (r == 5'd10) return 0;
        if (r == 5'd11) return 1;
        if (r == 5'd12) return 2;
        return -1;
    endfunction

    function automatic logic [31:0] shadow_out(input int i);
        if (i == 0) return ball_q;
        if (i == 1) return padl_q;
        return padr_q;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 3; i++) begin m_work[i] = '0; m_shad[i] = '0; end
        for (int i = 0; i < 4; i++) m_dcnt[i] = 0;
        m_count = '0;
        m_btn   = '0;
        m_ovr   = 1'b0;
    endtask

    task automatic m_write(input logic [4:0] r, input logic [31:0] d);
        if (sidx(r) >= 0) m_work[sidx(r)] = d;
    endtask

    // One vblank copy: shadows take the working words, the counter advances,
    // and each button sees one debounce sample of the level currently held.
    task automatic m_copy();
        for (int i = 0; i < 3; i++) m_shad[i] = m_work[i];
        m_count = m_count + 16'd1;
        for (int b = 0; b < 4; b++) begin
            if (btn_raw[b] == m_btn[b]) m_dcnt[b] = 0;
            else begin
                m_dcnt[b] = m_dcnt[b] + 1;
                if (m_dcnt[b] >= DEB) begin
                    m_btn[b]  = ~m_btn[b];
                    m_dcnt[b] = 0;
                end
            end
        end
    endtask

    task automatic proc_write(input logic [4:0] r, input logic [31:0] d);
        cyc();
        proc_we = 1'b1; proc_wreg = r; proc_wdata = d;
        m_write(r, d);
        #4;
        n_cmp++;
        if (rf_we !== 1'b1 || rf_wreg !== r || rf_wdata !== d) begin
            n_err++;
            $display("FAIL passthru_idle: got we=%b reg=%0d data=%h, want we=1 reg=%0d data=%h",
                     rf_we, rf_wreg, rf_wdata, r, d);
        end
        cyc();
        proc_we = 1'b0;
    endtask

    // One full frame starting from IDLE with V_SYNC high long enough.
    // hold: processor write cycles occupying the port after COPY.
    task automatic run_frame(input int hold, input bit do_fwd,
                             input logic [4:0] freg, input logic [31:0] fdata);
        cyc(); vga_vs = 1'b0;
        cyc();                  // edge N
        cyc();                  // edge N+1
        cyc();                  // edge N+2: COPY cycle
        if (do_fwd) begin
            proc_we = 1'b1; proc_wreg = freg; proc_wdata = fdata;
            m_write(freg, fdata);
        end
        #4;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (shadow_out(i) !== m_shad[i]) begin
                n_err++;
                $display("FAIL tear_free[%0d]: got %h want %h", i, shadow_out(i), m_shad[i]);
            end
        end
        n_cmp++;
        if (frame_count !== m_count) begin
            n_err++;
            $display("FAIL count_before_copy: got %h want %h", frame_count, m_count);
        end
        m_copy();
        cyc();                  // edge N+3: INJECT cycle
        vga_vs = 1'b1;
        for (int h = 0; h <= hold; h++) begin
            if (h < hold) begin
                proc_we = 1'b1;
                proc_wreg = 5'($urandom_range(0, 31));
                proc_wdata = $urandom;
                m_write(proc_wreg, proc_wdata);
            end else begin
                proc_we = 1'b0;
            end
            #4;
            if (h == 0) begin
                for (int i = 0; i < 3; i++) begin
                    n_cmp++;
                    if (shadow_out(i) !== m_shad[i]) begin
                        n_err++;
                        $display("FAIL shadow[%0d]: got %h want %h", i, shadow_out(i), m_shad[i]);
                    end
                end
                n_cmp++;
                if (frame_count !== m_count || btn_state !== m_btn || frame_overrun !== m_ovr) begin
                    n_err++;
                    $display("FAIL frame_state: got cnt=%h btn=%b ovr=%b want cnt=%h btn=%b ovr=%b",
                             frame_count, btn_state, frame_overrun, m_count, m_btn, m_ovr);
                end
            end
            n_cmp++;
            if (h < hold) begin
                if (rf_we !== 1'b1 || rf_wreg !== proc_wreg || rf_wdata !== proc_wdata || frame_tick !== 1'b0) begin
                    n_err++;
                    $display("FAIL proc_priority: got we=%b reg=%0d data=%h tick=%b want we=1 reg=%0d data=%h tick=0",
                             rf_we, rf_wreg, rf_wdata, frame_tick, proc_wreg, proc_wdata);
                end
            end else begin
                if (rf_we !== 1'b1 || rf_wreg !== 5'd13 || rf_wdata !== {28'b0, m_btn} || frame_tick !== 1'b0) begin
                    n_err++;
                    $display("FAIL inject: got we=%b reg=%0d data=%h tick=%b want we=1 reg=13 data=%h tick=0",
                             rf_we, rf_wreg, rf_wdata, frame_tick, {28'b0, m_btn});
                end
            end
            cyc();
        end
        #4;
        n_cmp++;
        if (frame_tick !== 1'b1 || rf_we !== 1'b0) begin
            n_err++;
            $display("FAIL frame_tick: got tick=%b we=%b want tick=1 we=0", frame_tick, rf_we);
        end
        cyc();
        #4;
        n_cmp++;
        if (frame_tick !== 1'b0) begin
            n_err++;
            $display("FAIL tick_pulse: got %b want 0", frame_tick);
        end
        cyc();
        cyc();
    endtask

    task automatic test_reset();
        reset = 1'b1; vga_vs = 1'b1; btn_raw = 4'b0;
        proc_we = 1'b1; proc_wreg = 5'd5; proc_wdata = 32'hA5;
        m_reset();
        cyc(); cyc();
        #2;
        n_cmp++;
        if (rf_we !== 1'b0 || rf_wreg !== 5'd5) begin
            n_err++;
            $display("FAIL rf_in_reset: got we=%b reg=%0d want we=0 reg=5", rf_we, rf_wreg);
        end
        cyc();
        reset = 1'b0;
        #4;
        n_cmp++;
        if (rf_we !== 1'b1 || rf_wreg !== 5'd5 || rf_wdata !== 32'hA5) begin
            n_err++;
            $display("FAIL rf_after_reset: got we=%b reg=%0d data=%h want we=1 reg=5 data=a5",
                     rf_we, rf_wreg, rf_wdata);
        end
        n_cmp++;
        if (ball_q !== 0 || padl_q !== 0 || padr_q !== 0 || frame_count !== 0 ||
            btn_state !== 0 || frame_tick !== 0 || frame_overrun !== 0) begin
            n_err++;
            $display("FAIL reset_state: got ball=%h padl=%h padr=%h cnt=%h btn=%b tick=%b ovr=%b want all 0",
                     ball_q, padl_q, padr_q, frame_count, btn_state, frame_tick, frame_overrun);
        end
        cyc();
        proc_we = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
    endtask

    task automatic test_shadow();
        proc_write(5'd10, 32'h0012_0034);
        cyc(); cyc();
        #4;
        n_cmp++;
        if (ball_q !== 32'h0) begin
            n_err++;
            $display("FAIL ball_mid_frame: got %h want 0", ball_q);
        end
        run_frame(0, 1'b0, 5'd0, 32'h0);
        n_cmp++;
        if (ball_q !== 32'h0012_0034 || frame_count !== 16'd1) begin
            n_err++;
            $display("FAIL ball_after_vblank: got ball=%h cnt=%h want ball=00120034 cnt=1", ball_q, frame_count);
        end
    endtask

    task automatic test_forward();
        proc_write(5'd11, 32'h11);
        run_frame(0, 1'b1, 5'd11, 32'h55);
        n_cmp++;
        if (padl_q !== 32'h55) begin
            n_err++;
            $display("FAIL forward_padl: got %h want 00000055", padl_q);
        end
        run_frame(1, 1'b1, 5'd12, $urandom);
    endtask

    task automatic test_arbitration();
        run_frame(5, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_debounce();
        btn_raw = 4'b0010;
        run_frame(0, 1'b0, 5'd0, 32'h0);
        btn_raw = 4'b0000;
        run_frame(0, 1'b0, 5'd0, 32'h0);
        n_cmp++;
        if (btn_state !== 4'b0000) begin
            n_err++;
            $display("FAIL debounce_glitch: got %b want 0000", btn_state);
        end
        btn_raw = 4'b0010;
        run_frame(0, 1'b0, 5'd0, 32'h0);
        n_cmp++;
        if (btn_state !== 4'b0000) begin
            n_err++;
            $display("FAIL debounce_first: got %b want 0000", btn_state);
        end
        run_frame(0, 1'b0, 5'd0, 32'h0);
        n_cmp++;
        if (btn_state !== 4'b0010) begin
            n_err++;
            $display("FAIL debounce_accept: got %b want 0010", btn_state);
        end
    endtask

    task automatic test_random();
        logic [4:0] r;
        for (int f = 0; f < 14; f++) begin
            if ($urandom_range(0, 2) == 0) btn_raw = 4'($urandom_range(0, 15));
            for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
                r = ($urandom_range(0, 1) == 1) ? 5'(10 + $urandom_range(0, 2)) : 5'($urandom_range(0, 31));
                proc_write(r, $urandom);
            end
            r = 5'(10 + $urandom_range(0, 2));
            run_frame(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), r, $urandom);
        end
    endtask

    task automatic test_overrun();
        cyc(); vga_vs = 1'b0;
        cyc(); cyc(); cyc();
        m_copy();
        cyc();
        vga_vs = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            if (c == 3) vga_vs = 1'b0;
            proc_we = 1'b1;
            proc_wreg = 5'($urandom_range(0, 31));
            proc_wdata = $urandom;
            m_write(proc_wreg, proc_wdata);
            if (c == 6) begin
                m_copy();
                m_ovr = 1'b1;
            end
            #4;
            n_cmp++;
            if (rf_we !== 1'b1 || rf_wreg !== proc_wreg || frame_overrun !== (c == 6)) begin
                n_err++;
                $display("FAIL overrun_cycle%0d: got we=%b reg=%0d ovr=%b want we=1 reg=%0d ovr=%b",
                         c, rf_we, rf_wreg, frame_overrun, proc_wreg, (c == 6));
            end
            cyc();
        end
        vga_vs = 1'b1;
        proc_we = 1'b0;
        #4;
        n_cmp++;
        if (rf_we !== 1'b1 || rf_wreg !== 5'd13 || rf_wdata !== {28'b0, m_btn} || frame_count !== m_count) begin
            n_err++;
            $display("FAIL overrun_inject: got we=%b reg=%0d data=%h cnt=%h want we=1 reg=13 data=%h cnt=%h",
                     rf_we, rf_wreg, rf_wdata, frame_count, {28'b0, m_btn}, m_count);
        end
        cyc(); cyc(); cyc(); cyc();
        run_frame(0, 1'b0, 5'd0, 32'h0);
        n_cmp++;
        if (frame_overrun !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_sticky: got %b want 1", frame_overrun);
        end
    endtask

    task automatic test_wrap();
        force dut.frame_count = 16'hFFFF;
        cyc();
        release dut.frame_count;
        m_count = 16'hFFFF;
        cyc();
        run_frame(0, 1'b0, 5'd0, 32'h0);
        n_cmp++;
        if (frame_count !== 16'h0000) begin
            n_err++;
            $display("FAIL count_wrap: got %h want 0000", frame_count);
        end
    endtask

    task automatic test_reset_mid_inject();
        cyc(); vga_vs = 1'b0;
        cyc(); cyc(); cyc();
        m_copy();
        cyc();
        vga_vs = 1'b1;
        proc_we = 1'b0; proc_wreg = 5'd7; proc_wdata = 32'hDEAD_BEEF;
        #2;
        n_cmp++;
        if (rf_we !== 1'b1 || rf_wreg !== 5'd13) begin
            n_err++;
            $display("FAIL inject_before_reset: got we=%b reg=%0d want we=1 reg=13", rf_we, rf_wreg);
        end
        reset = 1'b1;
        #1;
        m_reset();
        n_cmp++;
        if (rf_we !== 1'b0 || rf_wreg !== 5'd7 || rf_wdata !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL reset_abort: got we=%b reg=%0d data=%h want we=0 reg=7 data=deadbeef",
                     rf_we, rf_wreg, rf_wdata);
        end
        n_cmp++;
        if (frame_count !== 0 || ball_q !== 0 || btn_state !== 0 || frame_overrun !== 0) begin
            n_err++;
            $display("FAIL reset_clear: got cnt=%h ball=%h btn=%b ovr=%b want all 0",
                     frame_count, ball_q, btn_state, frame_overrun);
        end
        cyc(); cyc();
        reset = 1'b0;
        #4;
        n_cmp++;
        if (frame_tick !== 1'b0 || rf_we !== 1'b0) begin
            n_err++;
            $display("FAIL after_abort: got tick=%b we=%b want tick=0 we=0", frame_tick, rf_we);
        end
        for (int i = 0; i < 4; i++) cyc();
        run_frame(0, 1'b0, 5'd0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_shadow();
        test_forward();
        test_arbitration();
        test_debounce();
        test_random();
        test_overrun();
        test_wrap();
        test_reset_mid_inject();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pong_frame_scheduler.md
Name: pong_frame_scheduler

Overview:
- Sequences the game per video frame and arbitrates the regfile write port between the processor and itself.
- Snoops processor writes to the game-object registers (ball, left paddle, right paddle) and copies them to VGA-facing shadow outputs only at vertical-blank start, so the display never tears.
- Debounces the four move buttons once per frame and injects their state into a designated register.
- Sits between processor_processor and regfile, beside vga_controller.

Parameters:
- BALL_REG, 10: regfile index holding the ball word.
- PADL_REG, 11: regfile index holding the left paddle word.
- PADR_REG, 12: regfile index holding the right paddle word.
- BTN_REG, 13: regfile index that receives the injected button word.
- DEBOUNCE_FRAMES, 2: consecutive identical vblank samples needed to accept a button change (range 1–7).

Ports:
- clock  in  1  processor clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- vga_vs  in  1  VGA V_SYNC, active low, asynchronous to clock.
- btn_raw  in  4  {moveleft, moveright, moveup, movedown}, asynchronous.
- proc_we  in  1  processor ctrl_writeEnable.
- proc_wreg  in  5  processor ctrl_writeReg.
- proc_wdata  in  32  processor data_writeReg.
- rf_we  out  1  regfile ctrl_writeEnable.
- rf_wreg  out  5  regfile ctrl_writeReg.
- rf_wdata  out  32  regfile data_writeReg.
- ball_q  out  32  shadow ball word for VGA.
- padl_q  out  32  shadow left paddle word.
- padr_q  out  32  shadow right paddle word.
- btn_state  out  4  debounced buttons.
- frame_count  out  16  vblank counter.
- frame_tick  out  1  one-cycle pulse when the button word has been written.
- frame_overrun  out  1  sticky: a vblank occurred while an injection was still pending.

Behaviour:
- Reset (async, active-high): all outputs 0, working copies 0, debounce counters 0, synchronizers 0, state IDLE.
- Synchronizers: vga_vs and btn_raw each pass through 2 flops. vblank_evt is asserted when the synced vs is low and was high the previous cycle.
- Snoop: when proc_we=1 and proc_wreg equals BALL_REG, PADL_REG or PADR_REG, the matching working copy loads proc_wdata. A write to index 0 is never snooped.
- FSM state IDLE: rf_* = proc_* passthrough. On vblank_evt, go to COPY.
- FSM state COPY (1 cycle):
  - Shadows load the working copies. If the processor writes a shadowed register in this same cycle, the shadow takes proc_wdata (forwarded).
  - frame_count increments, wrapping FFFF→0000.
  - Debounce step runs.
  - rf_* stays passthrough.
  - Go to INJECT.
- FSM state INJECT:
  - If proc_we=0: rf_we=1, rf_wreg=BTN_REG, rf_wdata={28'b0, btn_state}; next cycle frame_tick=1 and state returns to IDLE.
  - If proc_we=1: passthrough and stay in INJECT. The processor always has priority and is never stalled.
- Overrun: a vblank_evt seen in INJECT sets frame_overrun, which is cleared only by reset. The FSM goes to COPY, and the newer btn_state is what gets injected.
- Debounce, per bit:
  - If the synced sample equals btn_state, the counter clears.
  - Otherwise the counter increments; when it reaches DEBOUNCE_FRAMES, btn_state flips and the counter clears.
  - Evaluated only in COPY.
- Latency: let N be the first rising edge that samples vga_vs low.
  - Shadows and frame_count update at edge N+3.
  - The earliest injection write is the cycle after N+3.
  - frame_tick is high the following cycle.
- Reset mid-injection: the write is aborted immediately and rf_* returns to passthrough with rf_we=0 while reset is high.

Decomposition:
- Shared package pong_pkg holds:
  - FSM state encoding (IDLE, COPY, INJECT).
  - Default register indices.
  - Button bit positions.
- One natural sub-module, pong_btn_debounce: per-bit synchronizer plus frame-based debounce counter, instantiated ×4.

Test Plan:
- Reset with rf passthrough: assert reset, drive proc_we=1, wreg=5, wdata=32'hA5 → after release rf_*=proc_*, all shadows 0, frame_count=0.
- Tear-free shadow: write BALL_REG=32'h0012_0034 mid-frame → ball_q stays 0 until vs falls, then equals 32'h0012_0034 at N+3, and frame_count=1.
- Forwarding: processor writes PADL_REG=32'h55 exactly in the COPY cycle → padl_q=32'h55 in the same update.
- Arbitration: hold proc_we=1 for 5 cycles after COPY → no injection during those cycles; on the first proc_we=0 cycle rf_wreg=13, rf_wdata=btn_state; frame_tick one cycle later.
- Debounce (DEBOUNCE_FRAMES=2): moveup high for 1 frame then low → btn_state unchanged; high for 2 vblanks → btn_state=4'b0010 after the second COPY.
- Overrun and wrap: keep proc_we=1 across two vblanks → frame_overrun=1 and stays set. Preload a count of FFFF, then one vblank → frame_count=0.
